spram_dma_arb: RTL and testbench

- Arbiter and DMA sequencer sitting directly upstream of the generic single-port RAM. It drives that RAM's addr/din/we/re pins.
- Multiplexes two requesters onto the single RAM port:
  - CPU data port, with `cpu_hold` back-pressure.
  - Built-in DMA engine that streams a block into the RAM or out of it.
- Provides the hold-off that lets DMA and hardware I/O share the RAM.

---
 rtl/spram_dma_arb.sv | 146 ++++++++++++++
 tb/tb_spram_dma_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_dma_arb.sv
// spram_dma_arb: arbiter and DMA sequencer in front of a single-port RAM.
// Two requesters share the RAM port: the CPU data port, which is back-pressured
// through cpu_hold, and a block DMA engine. The DMA engine either streams words
// into the RAM (WR) or streams them out of it (RD). A starvation counter gives
// the CPU one cycle after MAX_HOLD consecutive lost arbitrations.
module spram_dma_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic                  cpu_hold,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  dma_start,
  input  logic                  dma_dir,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [ADDR_WIDTH-1:0] dma_len,
  output logic                  dma_busy,
  output logic                  dma_done,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  localparam logic [3:0]            HOLD_LIM = 4'(MAX_HOLD);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]            hold_q, hold_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  busy_q, done_q;

  logic cpu_req, dma_want, dma_gnt, cpu_gnt, hold_max;

  // Per-cycle arbitration: DMA wins unless the CPU has been starved MAX_HOLD times.
  always_comb begin
    cpu_req  = cpu_we | cpu_re;
    dma_want = ((state_q == WR) && wr_valid) || ((state_q == RD) && (cnt_q != '0));
    hold_max = (hold_q == HOLD_LIM);
    dma_gnt  = dma_want && !(cpu_req && hold_max);
    cpu_gnt  = cpu_req && !dma_gnt;
  end

  // RAM port mux; with no grant the address rests on the DMA pointer.
  always_comb begin
    cpu_hold = cpu_req && dma_gnt;
    wr_ready = dma_gnt && (state_q == WR);
    ram_addr = ptr_q;
    ram_din  = wr_data;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    if (cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_we;
      ram_re   = cpu_re;
    end else if (dma_gnt) begin
      ram_we = (state_q == WR);
      ram_re = (state_q == RD);
    end
  end

  assign cpu_dout = ram_dout;
  assign rd_data  = ram_dout;
  assign rd_valid = rd_vld_q;
  assign dma_busy = busy_q;
  assign dma_done = done_q;

  // Next-state logic for the DMA sequencer, pointer/count and starvation counter.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    hold_d   = cpu_hold ? (hold_q + 4'd1) : 4'd0;
    rd_vld_d = dma_gnt && (state_q == RD);
    case (state_q)
      IDLE: begin
        if (dma_start) begin
          ptr_d = dma_addr;
          cnt_d = dma_len;
          if (dma_len == '0)  state_d = DONE;
          else if (dma_dir)   state_d = RD;
          else                state_d = WR;
        end
      end
      WR: begin
        if (dma_gnt) begin
          ptr_d = ptr_q + ONE;
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) state_d = DONE;
        end
      end
      RD: begin
        // Once every read is issued, leave on the cycle the last rd_valid shows.
        if (dma_gnt) begin
          ptr_d = ptr_q + ONE;
          cnt_d = cnt_q - ONE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state with async reset; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      hold_q   <= 4'd0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rd_vld_q <= rd_vld_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  // Datapath pointer and remaining count; only meaningful while a transfer is active.
  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_spram_dma_arb.sv
// Self-checking bench for spram_dma_arb: a behavioural RAM sits on the RAM pins,
// and a transfer-level reference model predicts grants, stream traffic and the
// final memory image from the arbitration and DMA rules.
module tb_spram_dma_arb;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          arstn;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_we, cpu_re, cpu_hold;
  logic [DW-1:0] cpu_dout;
  logic          dma_start, dma_dir;
  logic [AW-1:0] dma_addr, dma_len;
  logic          dma_busy, dma_done;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  spram_dma_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .arstn(arstn),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_hold(cpu_hold), .cpu_dout(cpu_dout),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
    .ram_dout(ram_dout)
  );

  // Single-port RAM with one-cycle read latency (read returns old data on we&re)
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q = '0;
  always @(posedge clk) begin
    if (ram_re) dout_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end
  assign ram_dout = dout_q;

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_busy, m_done, m_dir;
  logic [AW-1:0] m_ptr;
  int            m_left, m_streak;
  bit            x_rdv, x_cpurd;
  logic [DW-1:0] x_rdata, x_cpudata;
  bit            last_hold, last_wr_acc;

  int n_chk = 0;
  int n_err = 0;
  int n_rdv, n_hold, n_acc;

  task automatic chk_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_done = 0; m_streak = 0; m_left = 0;
    x_rdv = 0; x_cpurd = 0; last_hold = 0; last_wr_acc = 0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    bit creq, want, dg, cg, hold;
    #1;
    creq = cpu_we | cpu_re;
    want = m_busy && !m_done && (m_left > 0) && (m_dir || wr_valid);
    dg   = want && !(creq && m_streak == MH);
    cg   = creq && !dg;
    hold = creq && dg;
    chk_eq("cpu_hold", 32'(cpu_hold), 32'(hold));
    chk_eq("wr_ready", 32'(wr_ready), 32'(dg && !m_dir));
    chk_eq("ram_we", 32'(ram_we), 32'(cg ? cpu_we : (dg && !m_dir)));
    chk_eq("ram_re", 32'(ram_re), 32'(cg ? cpu_re : (dg && m_dir)));
    if (cg) chk_eq("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
    if (dg) chk_eq("ram_addr_dma", 32'(ram_addr), 32'(m_ptr));
    if (cg && cpu_we) chk_eq("ram_din_cpu", 32'(ram_din), 32'(cpu_din));
    if (dg && !m_dir) chk_eq("ram_din_dma", 32'(ram_din), 32'(wr_data));
    n_hold += int'(cpu_hold);
    n_acc  += int'(ram_we | ram_re);
    @(posedge clk);
    x_rdv = 0;
    x_cpurd = 0;
    if (cg) begin
      if (cpu_re) begin x_cpurd = 1; x_cpudata = ref_mem[cpu_addr]; end
      if (cpu_we) ref_mem[cpu_addr] = cpu_din;
    end
    if (dg) begin
      if (m_dir) begin x_rdv = 1; x_rdata = ref_mem[m_ptr]; end
      else ref_mem[m_ptr] = wr_data;
      m_ptr  = AW'(m_ptr + 1);
      m_left = m_left - 1;
    end
    m_streak    = hold ? m_streak + 1 : 0;
    last_hold   = hold;
    last_wr_acc = dg && !m_dir;
    if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (dma_start) begin
        m_busy = 1; m_dir = dma_dir; m_ptr = dma_addr;
        m_left = int'(dma_len); m_done = (dma_len == '0);
      end
    end else if (m_left == 0 && (!m_dir || !dg)) begin
      m_done = 1;
    end
    @(negedge clk);
    chk_eq("dma_busy", 32'(dma_busy), 32'(m_busy));
    chk_eq("dma_done", 32'(dma_done), 32'(m_done));
    chk_eq("rd_valid", 32'(rd_valid), 32'(x_rdv));
    if (x_rdv) chk_eq("rd_data", 32'(rd_data), 32'(x_rdata));
    if (x_cpurd) chk_eq("cpu_dout", 32'(cpu_dout), 32'(x_cpudata));
    n_rdv += int'(rd_valid);
  endtask

  task automatic do_reset();
    cpu_we = 0; cpu_re = 0; dma_start = 0; wr_valid = 0;
    arstn = 0;
    #1;
    chk_eq("rst_busy", 32'(dma_busy), 32'd0);
    chk_eq("rst_done", 32'(dma_done), 32'd0);
    chk_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk_eq("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk_eq("rst_ram_we_re", 32'({ram_we, ram_re, wr_ready}), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    arstn = 1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 31));
    return AW'(10'h3F0 + AW'($urandom_range(0, 15)));
  endfunction

  task automatic rand_cpu();
    if (!last_hold) begin
      if ($urandom_range(0, 2) == 0) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_re = cpu_we ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_addr = pick_addr();
        cpu_din  = DW'($urandom);
      end else begin
        cpu_we = 0; cpu_re = 0;
      end
    end
  endtask

  task automatic finish_dma(bit traffic, bit wv_rand);
    int guard = 0;
    while (m_busy && guard < 500) begin
      if (last_wr_acc) wr_data = DW'(wr_data + 1);
      if (wv_rand) wr_valid = ($urandom_range(0, 3) != 0);
      if (traffic) begin
        rand_cpu();
        dma_start = ($urandom_range(0, 7) == 0);
        dma_dir   = 1'($urandom_range(0, 1));
        dma_addr  = pick_addr();
        dma_len   = AW'($urandom_range(0, 12));
      end
      cycle();
      guard++;
    end
    dma_start = 0;
    chk_eq("dma_finished", 32'(m_busy), 32'd0);
  endtask

  task automatic run_dma(bit dir, logic [AW-1:0] addr, logic [AW-1:0] len, bit traffic, bit wv_rand);
    dma_start = 1; dma_dir = dir; dma_addr = addr; dma_len = len;
    if (traffic) rand_cpu();
    cycle();
    dma_start = 0;
    finish_dma(traffic, wv_rand);
  endtask

  initial begin
    int guard;
    int diffs;
    arstn = 0;
    cpu_addr = '0; cpu_din = '0; cpu_we = 0; cpu_re = 0;
    dma_start = 0; dma_dir = 0; dma_addr = '0; dma_len = '0;
    wr_valid = 0; wr_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    model_clear();
    @(negedge clk);
    do_reset();

    // CPU write then read at address 5
    n_hold = 0;
    cpu_we = 1; cpu_addr = AW'(5); cpu_din = 16'h1234;
    cycle();
    cpu_we = 0; cpu_re = 1;
    cycle();
    chk_eq("t1_cpu_dout", 32'(cpu_dout), 32'h1234);
    cpu_re = 0;
    cycle();
    chk_eq("t1_no_hold", 32'(n_hold), 32'd0);

    // DMA WR across the address wrap
    wr_valid = 1; wr_data = 16'h00A0;
    run_dma(0, 10'h3FE, 10'd4, 0, 0);
    chk_eq("t2_mem3FE", 32'(mem[10'h3FE]), 32'h00A0);
    chk_eq("t2_mem3FF", 32'(mem[10'h3FF]), 32'h00A1);
    chk_eq("t2_mem000", 32'(mem[10'h000]), 32'h00A2);
    chk_eq("t2_mem001", 32'(mem[10'h001]), 32'h00A3);
    wr_valid = 0;

    // DMA RD of the same block
    n_rdv = 0;
    run_dma(1, 10'h3FE, 10'd4, 0, 0);
    chk_eq("t3_rd_count", 32'(n_rdv), 32'd4);

    // CPU read held across a 12-word WR: four holds per granted slot
    n_hold = 0;
    cpu_re = 1; cpu_addr = AW'(7); wr_valid = 1;
    run_dma(0, 10'h100, 10'd12, 0, 0);
    chk_eq("t4_hold_cycles", 32'(n_hold), 32'd12);
    cpu_re = 0;
    cycle();

    // Zero-length transfer: a done pulse and no RAM activity
    n_acc = 0;
    run_dma(0, 10'h020, 10'd0, 0, 0);
    chk_eq("t5_len0_access", 32'(n_acc), 32'd0);
    // Start pulse while busy is ignored
    wr_valid = 0;
    dma_start = 1; dma_dir = 0; dma_addr = 10'h040; dma_len = 10'd3;
    cycle();
    dma_start = 1; dma_dir = 1; dma_addr = 10'h200; dma_len = 10'd5;
    cycle();
    dma_start = 0;
    cycle();
    wr_valid = 1;
    finish_dma(0, 0);

    // Reset in the middle of a 6-word RD
    wr_valid = 0;
    n_rdv = 0;
    dma_start = 1; dma_dir = 1; dma_addr = 10'h3FE; dma_len = 10'd6;
    cycle();
    dma_start = 0;
    guard = 0;
    while (n_rdv < 2 && guard < 20) begin cycle(); guard++; end
    chk_eq("t6_two_words", 32'(n_rdv), 32'd2);
    do_reset();
    n_rdv = 0;
    run_dma(1, 10'h3FE, 10'd4, 0, 0);
    chk_eq("t6_rd_after_reset", 32'(n_rdv), 32'd4);

    // Randomized transfers with background CPU traffic
    for (int t = 0; t < 30; t++) begin
      run_dma(1'($urandom_range(0, 1)), pick_addr(), AW'($urandom_range(0, 12)), 1, 1);
    end
    cpu_we = 0; cpu_re = 0; wr_valid = 0;
    cycle();

    diffs = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk_eq("mem_image", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
